// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and FSM codes for the IF stage and its icache.
package if_fetch_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INST_W  = 32;

  localparam logic [INST_W-1:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic              RST_ENABLE = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] BYTES_PER_WORD = 3'd4;

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line icache: combinational lookup, single write port.
// Tag and data arrays are not reset; only the valid bits are.
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int unsigned IDX_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_pc_i,
  output logic              hit_o,
  output logic [INST_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_pc_i,
  input  logic [INST_W-1:0] wr_data_i
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [INST_W-1:0] data_q [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             unused_pc_lsb;

  assign rd_idx = rd_pc_i[IDX_W+1:2];
  assign wr_idx = wr_pc_i[IDX_W+1:2];
  assign rd_tag = rd_pc_i[ADDR_W-1:IDX_W+2];
  assign wr_tag = wr_pc_i[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsb = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// IF stage: PC, icache lookup, byte-serial miss fill. Hits return in the same cycle;
// a miss raises stallreq_o for 5 cycles plus one per mem_busy_i cycle while a byte is still to issue.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned IDX_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               br_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  input  logic               mem_busy_i,
  input  logic [7:0]         mem_rdata_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               stallreq_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [INST_W-1:0]  if_inst_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        iss_cnt_q, iss_cnt_d;
  logic [2:0]        rcv_cnt_q, rcv_cnt_d;
  logic              pending_q, pending_d;
  logic              wrote_q, wrote_d;
  logic [3:0][7:0]   bytes_q, bytes_d;

  logic              hit;
  logic [INST_W-1:0] hit_data;
  logic              issue;
  logic              out_vld;
  logic              stall_req;
  logic              cache_we;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[STALL_W-1:2], stall_i[0]};

  // Write once per fill, on the first DONE cycle, even if DONE is held by a stall.
  assign cache_we = (state_q == ST_DONE) && !wrote_q && (rst != RST_ENABLE);

  if_fetch_icache #(.IDX_W(IDX_W)) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rd_pc_i   (pc_q),
    .hit_o     (hit),
    .rd_data_o (hit_data),
    .we_i      (cache_we),
    .wr_pc_i   (pc_q),
    .wr_data_i (bytes_q)
  );

  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    pending_d = 1'b0;
    wrote_d   = wrote_q;
    bytes_d   = bytes_q;
    issue     = 1'b0;
    out_vld   = 1'b0;
    stall_req = 1'b0;
    if (br_i) begin
      pc_d      = br_target_i;
      state_d   = ST_IDLE;
      iss_cnt_d = '0;
      rcv_cnt_d = '0;
      wrote_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            out_vld = 1'b1;
            if (!stall_i[1]) pc_d = pc_q + 32'd4;
          end else begin
            // The miss proceeds even under stall, since ctrl stalls us because of it.
            stall_req = 1'b1;
            state_d   = ST_FILL;
            issue     = !mem_busy_i;
          end
        end
        ST_FILL: begin
          stall_req = 1'b1;
          issue     = (iss_cnt_q != BYTES_PER_WORD) && !mem_busy_i;
          if (pending_q) begin
            bytes_d[rcv_cnt_q[1:0]] = mem_rdata_i;
            rcv_cnt_d = rcv_cnt_q + 3'd1;
            if (rcv_cnt_q == BYTES_PER_WORD - 3'd1) begin
              state_d   = ST_DONE;
              rcv_cnt_d = '0;
              iss_cnt_d = '0;
            end
          end
        end
        ST_DONE: begin
          out_vld = 1'b1;
          wrote_d = 1'b1;
          if (!stall_i[1]) begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_IDLE;
            wrote_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (issue) begin
        iss_cnt_d = iss_cnt_q + 3'd1;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q      <= '0;
      state_q   <= ST_IDLE;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
      pending_q <= 1'b0;
      wrote_q   <= 1'b0;
      bytes_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      pending_q <= pending_d;
      wrote_q   <= wrote_d;
      bytes_q   <= bytes_d;
    end
  end

  assign mem_req_o  = issue && (rst != RST_ENABLE);
  assign mem_addr_o = pc_q + {29'd0, iss_cnt_q};
  assign stallreq_o = stall_req && (rst != RST_ENABLE);
  assign if_pc_o    = (out_vld && (rst != RST_ENABLE)) ? pc_q : ZERO_WORD;
  assign if_inst_o  = (out_vld && (rst != RST_ENABLE))
                      ? ((state_q == ST_DONE) ? bytes_q : hit_data) : ZERO_WORD;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: stimulus pushes expected fetches and byte addresses,
// a monitor pops and compares whenever the DUT presents an instruction or a read.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall_i;
  logic               br_i;
  logic [31:0]        br_target_i;
  logic               mem_busy_i;
  logic [7:0]         mem_rdata_i;
  logic               mem_req_o;
  logic [31:0]        mem_addr_o;
  logic               stallreq_o;
  logic [31:0]        if_pc_o;
  logic [31:0]        if_inst_o;

  if_fetch #(.IDX_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_i        (br_i),
    .br_target_i (br_target_i),
    .mem_busy_i  (mem_busy_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .stallreq_o  (stallreq_o),
    .if_pc_o     (if_pc_o),
    .if_inst_o   (if_inst_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  stalls;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [7:0]  mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          run    = 0;
  bit          front_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= mem[mem_addr_o[9:0]];
    else           mem_rdata_i <= 8'hEE;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, after inputs and combinational outputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        run = 0;
        front_seen = 0;
      end else begin
        if (mem_busy_i) check("no_req_while_busy", {63'd0, mem_req_o}, 64'd0);
        if (mem_req_o) begin
          if (addr_q.size() == 0) check("unexpected_req_addr", {32'd0, mem_addr_o}, 64'hFFFF_FFFF);
          else check("req_addr", {32'd0, mem_addr_o}, {32'd0, addr_q.pop_front()});
        end
        if (br_i) begin
          check("br_cycle_outputs", {31'd0, stallreq_o, if_pc_o}, 64'd0);
          check("br_cycle_inst", {32'd0, if_inst_o}, 64'd0);
          run = 0;
        end else if (stallreq_o) begin
          check("stall_outputs_zero", {if_pc_o, if_inst_o}, 64'd0);
          run++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_output", {if_pc_o, if_inst_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q[0];
          check("fetch_pc_inst", {if_pc_o, if_inst_o}, {e.pc, e.inst});
          if (!front_seen) check("stall_cycles", 64'(run), 64'(e.stalls));
          run = 0;
          if (stall_i[1]) begin
            front_seen = 1;
          end else begin
            void'(exp_q.pop_front());
            front_seen = 0;
          end
        end
      end
    end
  end

  task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [7:0] stalls);
    exp_t e;
    e.pc = pc; e.inst = inst; e.stalls = stalls;
    exp_q.push_back(e);
  endtask

  task automatic expect_addrs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(base + 32'(i));
  endtask

  task automatic redirect(input logic [31:0] tgt);
    @(negedge clk);
    br_i = 1'b1;
    br_target_i = tgt;
    @(negedge clk);
    br_i = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    #1;
    while (stallreq_o && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (stallreq_o) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=stalled required=output within 40 cycles", name);
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = '0; br_i = 1'b0; br_target_i = '0; mem_busy_i = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    {mem[3], mem[2], mem[1], mem[0]}                 = 32'h0010_0513;
    {mem[7], mem[6], mem[5], mem[4]}                 = 32'h0000_006F;
    {mem['h13], mem['h12], mem['h11], mem['h10]}     = 32'h0031_01B3;
    {mem['h33], mem['h32], mem['h31], mem['h30]}     = 32'h1000_0537;
    {mem['h37], mem['h36], mem['h35], mem['h34]}     = 32'h0000_0013;
    {mem['h103], mem['h102], mem['h101], mem['h100]} = 32'h0020_0093;
    {mem['h203], mem['h202], mem['h201], mem['h200]} = 32'h0030_0113;

    repeat (3) @(negedge clk);
    #1;
    check("reset_req_stall", {62'd0, mem_req_o, stallreq_o}, 64'd0);
    check("reset_pc_inst", {if_pc_o, if_inst_o}, 64'd0);

    // Cold start at 0.
    expect_fetch(32'h0, 32'h0010_0513, 8'd5);
    expect_addrs(32'h0, 4);
    @(negedge clk);
    rst = 1'b0;
    wait_out("cold");

    // Loop back to 0: hit with no stall.
    expect_fetch(32'h0, 32'h0010_0513, 8'd0);
    redirect(32'h0);
    wait_out("hit0");

    // Port busy for 3 cycles after byte 1 issued.
    expect_fetch(32'h10, 32'h0031_01B3, 8'd8);
    expect_addrs(32'h10, 4);
    redirect(32'h10);
    @(negedge clk);
    @(negedge clk);
    mem_busy_i = 1'b1;
    repeat (3) @(negedge clk);
    mem_busy_i = 1'b0;
    wait_out("busy");

    // Branch mid-fill after two issues; the in-flight byte must be dropped.
    expect_addrs(32'h20, 2);
    expect_fetch(32'h100, 32'h0020_0093, 8'd5);
    expect_addrs(32'h100, 4);
    redirect(32'h20);
    @(negedge clk);
    redirect(32'h100);
    wait_out("abort");

    // Stall held over DONE for two cycles, then PC advances to 0x34.
    expect_fetch(32'h30, 32'h1000_0537, 8'd5);
    expect_addrs(32'h30, 4);
    expect_fetch(32'h34, 32'h0000_0013, 8'd5);
    expect_addrs(32'h34, 4);
    redirect(32'h30);
    wait_out("done_stall");
    stall_i = 6'b000010;
    @(negedge clk);
    @(negedge clk);
    stall_i = '0;
    @(negedge clk);
    wait_out("after_release");

    // Aliasing on index 0: 0x200 evicts 0x000, which then misses again.
    expect_fetch(32'h200, 32'h0030_0113, 8'd5);
    expect_addrs(32'h200, 4);
    redirect(32'h200);
    wait_out("alias_200");
    expect_fetch(32'h0, 32'h0010_0513, 8'd5);
    expect_addrs(32'h0, 4);
    redirect(32'h0);
    wait_out("alias_000");
    expect_fetch(32'h0, 32'h0010_0513, 8'd0);
    redirect(32'h0);
    wait_out("refill_hit");

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("fetches_left", 64'(exp_q.size()), 64'd0);
    check("addrs_left", 64'(addr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
